// File: rtl/l1_ahb_mtx_pkg.sv
// L1 AHB bus matrix shared definitions.
// AHB transfer/burst encodings and arbitration mode constants.
package l1_ahb_mtx_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // SEQ beats still owed after the NONSEQ of a burst
   function automatic logic [3:0] burst_seq_beats(input logic [2:0] hburst);
      logic [3:0] beats;
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
         HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
         HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
         default:                      beats = 4'd0;
      endcase
      return beats;
   endfunction

endpackage

// File: rtl/l1_ahb_mtx_rr_pick.sv
// L1 AHB matrix arbiter pick logic.
// Finds first set request strictly after base, wrapping.
module l1_ahb_mtx_rr_pick #(
   parameter int NUM_PORTS = 3,
   parameter int PORT_W    = 2
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PORT_W-1:0]    base,
   output logic                 found,
   output logic [PORT_W-1:0]    idx
);

   logic [PORT_W:0]      shamt;
   logic [2*NUM_PORTS-1:0] dbl;
   logic [NUM_PORTS-1:0] rot;
   logic [PORT_W:0]      pos;
   logic [PORT_W:0]      sum;
   logic [PORT_W:0]      wrap;

   assign shamt = {1'b0, base} + (PORT_W+1)'(1);
   assign dbl   = {req, req};
   assign rot   = NUM_PORTS'(dbl >> shamt);

   // lowest set bit of the rotated vector wins
   always_comb begin
      found = 1'b0;
      pos   = '0;
      for (int j = NUM_PORTS - 1; j >= 0; j--) begin
         if (rot[j]) begin
            found = 1'b1;
            pos   = (PORT_W+1)'(j);
         end
      end
   end

   assign sum  = shamt + pos;
   assign wrap = (sum >= (PORT_W+1)'(NUM_PORTS)) ?
                 sum - (PORT_W+1)'(NUM_PORTS) : sum;
   assign idx  = wrap[PORT_W-1:0];

endmodule

// File: rtl/l1_ahb_mtx_arb_param.sv
// L1 AHB matrix output-stage arbiter.
// Fixed/RR selection with burst and lock hold.
module l1_ahb_mtx_arb_param
   import l1_ahb_mtx_pkg::*;
#(
   parameter int NUM_PORTS  = 3,
   parameter int ARB_MODE   = ARB_FIXED,
   parameter int BURST_HOLD = 1,
   localparam int PORT_W =
      ($clog2(NUM_PORTS) > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic [NUM_PORTS-1:0] req_port,
   input  logic                 HREADYM,
   input  logic                 HSELM,
   input  logic [1:0]           HTRANSM,
   input  logic [2:0]           HBURSTM,
   input  logic                 HMASTLOCKM,
   output logic [PORT_W-1:0]    addr_in_port,
   output logic                 no_port,
   output logic                 burst_active
);

   logic                 tr_idle;
   logic                 tr_busy;
   logic                 tr_nonseq;
   logic                 tr_seq;
   logic                 xfer_act;
   logic [NUM_PORTS-1:0] own;
   logic [NUM_PORTS-1:0] cand;
   logic [PORT_W-1:0]    base;
   logic                 pick_ok;
   logic [PORT_W-1:0]    pick_idx;
   logic [PORT_W-1:0]    last_grant;
   logic [3:0]           beat_cnt;
   logic [3:0]           beat_nxt;
   logic                 hold_burst;
   logic [PORT_W-1:0]    addr_nxt;
   logic                 no_nxt;
   logic                 grant_ld;

   assign tr_idle   = (HTRANSM == HTRANS_IDLE);
   assign tr_busy   = (HTRANSM == HTRANS_BUSY);
   assign tr_nonseq = (HTRANSM == HTRANS_NONSEQ);
   assign tr_seq    = (HTRANSM == HTRANS_SEQ);
   assign xfer_act  = HSELM & ~tr_idle;

   // current owner stays a candidate while its transfer is live
   always_comb begin
      own = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         own[i] = (addr_in_port == PORT_W'(i));
      end
   end

   assign cand = req_port | (own & {NUM_PORTS{xfer_act}});
   assign base = (ARB_MODE == ARB_RR) ?
                 last_grant : PORT_W'(NUM_PORTS - 1);

   l1_ahb_mtx_rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .PORT_W    (PORT_W)
   ) u_pick (
      .req   (cand),
      .base  (base),
      .found (pick_ok),
      .idx   (pick_idx)
   );

   // burst hold and beat counter next value
   always_comb begin
      hold_burst = 1'b0;
      beat_nxt   = beat_cnt;
      if (BURST_HOLD != 0) begin
         hold_burst = HSELM &
            ((tr_nonseq & (burst_seq_beats(HBURSTM) != 4'd0)) |
             (tr_seq & (beat_cnt > 4'd1)) |
             (tr_busy & (beat_cnt != 4'd0)));
         if (!HSELM)
            beat_nxt = 4'd0;
         else if (tr_nonseq)
            beat_nxt = burst_seq_beats(HBURSTM);
         else if (tr_seq && beat_cnt != 4'd0)
            beat_nxt = beat_cnt - 4'd1;
         else if (tr_idle)
            beat_nxt = 4'd0;
      end else begin
         beat_nxt = 4'd0;
      end
   end

   // grant decision: lock, burst, arbitration, select-hold, none
   always_comb begin
      addr_nxt = addr_in_port;
      no_nxt   = 1'b1;
      grant_ld = 1'b0;
      if (HMASTLOCKM) begin
         no_nxt = 1'b0;
      end else if (hold_burst) begin
         no_nxt = 1'b0;
      end else if (pick_ok) begin
         addr_nxt = pick_idx;
         no_nxt   = 1'b0;
         grant_ld = 1'b1;
      end else if (HSELM) begin
         no_nxt = 1'b0;
      end
   end

   // state registers advance only on accepted slave cycles
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_in_port <= '0;
         no_port      <= 1'b1;
         last_grant   <= PORT_W'(NUM_PORTS - 1);
         beat_cnt     <= 4'd0;
      end else if (HREADYM) begin
         addr_in_port <= addr_nxt;
         no_port      <= no_nxt;
         beat_cnt     <= beat_nxt;
         if (grant_ld)
            last_grant <= pick_idx;
      end
   end

   assign burst_active = (BURST_HOLD != 0) && (beat_cnt != 4'd0);

endmodule

// File: tb/tb_l1_ahb_mtx_arb_param.sv
// Bench for l1_ahb_mtx_arb_param.
// Fixed N=3 and round-robin N=4 instances, scoreboard checked.
module tb_l1_ahb_mtx_arb_param;
   import l1_ahb_mtx_pkg::*;

   logic       HCLK = 1'b0;
   logic       HRESETn;
   logic [2:0] req_f;
   logic [3:0] req_r;
   logic       HREADYM;
   logic       HSELM;
   logic [1:0] HTRANSM;
   logic [2:0] HBURSTM;
   logic       HMASTLOCKM;
   logic [1:0] addr_f;
   logic [1:0] addr_r;
   logic       nop_f;
   logic       nop_r;
   logic       ba_f;
   logic       ba_r;

   typedef struct {
      int    cyc;
      int    dut;
      int    addr;
      bit    nop;
      bit    ba;
      string name;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_mis = 0;
   bit   done = 1'b0;
   bit   done_chk = 1'b0;
   logic [1:0] aa;
   logic       an;
   logic       ab;

   always #5 HCLK = ~HCLK;

   always @(posedge HCLK) cyc <= cyc + 1;

   l1_ahb_mtx_arb_param #(
      .NUM_PORTS  (3),
      .ARB_MODE   (ARB_FIXED),
      .BURST_HOLD (1)
   ) u_fix (
      .HCLK         (HCLK),
      .HRESETn      (HRESETn),
      .req_port     (req_f),
      .HREADYM      (HREADYM),
      .HSELM        (HSELM),
      .HTRANSM      (HTRANSM),
      .HBURSTM      (HBURSTM),
      .HMASTLOCKM   (HMASTLOCKM),
      .addr_in_port (addr_f),
      .no_port      (nop_f),
      .burst_active (ba_f)
   );

   l1_ahb_mtx_arb_param #(
      .NUM_PORTS  (4),
      .ARB_MODE   (ARB_RR),
      .BURST_HOLD (1)
   ) u_rr (
      .HCLK         (HCLK),
      .HRESETn      (HRESETn),
      .req_port     (req_r),
      .HREADYM      (HREADYM),
      .HSELM        (HSELM),
      .HTRANSM      (HTRANSM),
      .HBURSTM      (HBURSTM),
      .HMASTLOCKM   (HMASTLOCKM),
      .addr_in_port (addr_r),
      .no_port      (nop_r),
      .burst_active (ba_r)
   );

   // monitor: pop every expectation due this cycle and compare
   always @(negedge HCLK) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         n_cmp++;
         aa = (e.dut == 0) ? addr_f : addr_r;
         an = (e.dut == 0) ? nop_f : nop_r;
         ab = (e.dut == 0) ? ba_f : ba_r;
         if (e.cyc != cyc || aa !== 2'(e.addr) ||
             an !== e.nop || ab !== e.ba) begin
            n_mis++;
            $display("FAIL %s: got addr=%0d no_port=%0b burst=%0b want addr=%0d no_port=%0b burst=%0b (cyc %0d/%0d)",
                     e.name, aa, an, ab, e.addr, e.nop, e.ba, cyc, e.cyc);
         end
      end
      if (HRESETn) begin
         n_cmp++;
         assert (!$isunknown({addr_f, nop_f, ba_f, addr_r, nop_r, ba_r}))
         else begin
            n_mis++;
            $display("FAIL xcheck: got %b want no X/Z",
                     {addr_f, nop_f, ba_f, addr_r, nop_r, ba_r});
         end
      end
      if (done && !done_chk) begin
         n_cmp++;
         if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL leftover: got %0d pending want 0", sb.size());
         end
         done_chk = 1'b1;
      end
   end

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic exp_at(input int lag, input string nm, input int dut,
                         input int a, input bit n, input bit b);
      exp_t x;
      x.cyc  = cyc + lag;
      x.dut  = dut;
      x.addr = a;
      x.nop  = n;
      x.ba   = b;
      x.name = nm;
      sb.push_back(x);
   endtask

   task automatic bus(input logic sel, input logic [1:0] tr,
                      input logic [2:0] hb, input logic lk);
      HSELM      = sel;
      HTRANSM    = tr;
      HBURSTM    = hb;
      HMASTLOCKM = lk;
   endtask

   // async reset checked before any clock edge; prior cycle pushes nothing
   task automatic do_reset(input string nm);
      HRESETn = 1'b0;
      exp_at(0, {nm, "_f"}, 0, 0, 1'b1, 1'b0);
      exp_at(0, {nm, "_r"}, 1, 0, 1'b1, 1'b0);
      tick();
      HRESETn = 1'b1;
   endtask

   initial begin
      HRESETn = 1'b0;
      req_f   = '0;
      req_r   = '0;
      HREADYM = 1'b1;
      bus(1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
      tick();
      tick();

      // T1 reset and idle release
      exp_at(0, "rst_f", 0, 0, 1'b1, 1'b0);
      exp_at(0, "rst_r", 1, 0, 1'b1, 1'b0);
      HRESETn = 1'b1;
      exp_at(1, "rel_f", 0, 0, 1'b1, 1'b0);
      exp_at(1, "rel_r", 1, 0, 1'b1, 1'b0);
      tick();

      // T2 fixed priority
      req_f = 3'b110; exp_at(1, "fix_p1", 0, 1, 1'b0, 1'b0); tick();
      req_f = 3'b111; exp_at(1, "fix_p0", 0, 0, 1'b0, 1'b0); tick();
      req_f = 3'b000; exp_at(1, "fix_none", 0, 0, 1'b1, 1'b0); tick();
      tick();

      // T3 round robin
      do_reset("rst2");
      req_r = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         exp_at(1, "rr_all", 1, i % 4, 1'b0, 1'b0);
         tick();
      end
      req_r = 4'b1010; exp_at(1, "rr_skip", 1, 3, 1'b0, 1'b0); tick();
      exp_at(1, "rr_wrap", 1, 1, 1'b0, 1'b0); tick();
      req_r = 4'b0000; exp_at(1, "rr_none", 1, 1, 1'b1, 1'b0); tick();

      // T4 INCR4 burst with BUSY, port 0 waiting
      req_f = 3'b100; exp_at(1, "b_own2", 0, 2, 1'b0, 1'b0); tick();
      req_f = 3'b101;
      bus(1'b1, HTRANS_NONSEQ, HBURST_INCR4, 1'b0);
      exp_at(1, "b_ns", 0, 2, 1'b0, 1'b1); tick();
      bus(1'b1, HTRANS_SEQ, HBURST_INCR4, 1'b0);
      exp_at(1, "b_s1", 0, 2, 1'b0, 1'b1); tick();
      bus(1'b1, HTRANS_BUSY, HBURST_INCR4, 1'b0);
      exp_at(1, "b_busy", 0, 2, 1'b0, 1'b1); tick();
      bus(1'b1, HTRANS_SEQ, HBURST_INCR4, 1'b0);
      exp_at(1, "b_s2", 0, 2, 1'b0, 1'b1); tick();
      exp_at(1, "b_s3", 0, 0, 1'b0, 1'b0); tick();
      req_f = 3'b000;
      bus(1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
      exp_at(1, "b_idle", 0, 0, 1'b1, 1'b0); tick();

      // T5 lock, lock with burst, then wait states
      req_f = 3'b100; exp_at(1, "l_own2", 0, 2, 1'b0, 1'b0); tick();
      req_f = 3'b011;
      bus(1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
      exp_at(1, "l_hold1", 0, 2, 1'b0, 1'b0); tick();
      exp_at(1, "l_hold2", 0, 2, 1'b0, 1'b0); tick();
      req_f = 3'b001;
      bus(1'b1, HTRANS_NONSEQ, HBURST_INCR4, 1'b1);
      exp_at(1, "l_burst", 0, 2, 1'b0, 1'b1); tick();
      bus(1'b1, HTRANS_SEQ, HBURST_INCR4, 1'b1);
      exp_at(1, "l_bseq", 0, 2, 1'b0, 1'b1); tick();
      req_f = 3'b000;
      bus(1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
      exp_at(1, "l_end", 0, 2, 1'b1, 1'b0); tick();
      req_f = 3'b100; exp_at(1, "w_pre", 0, 2, 1'b0, 1'b0); tick();
      HREADYM = 1'b0;
      req_f = 3'b001; exp_at(1, "w_hold1", 0, 2, 1'b0, 1'b0); tick();
      req_f = 3'b010; exp_at(1, "w_hold2", 0, 2, 1'b0, 1'b0); tick();
      req_f = 3'b011; exp_at(1, "w_hold3", 0, 2, 1'b0, 1'b0); tick();
      HREADYM = 1'b1;
      req_f = 3'b001; exp_at(1, "w_go", 0, 0, 1'b0, 1'b0); tick();

      // T6 WRAP8 cut short by IDLE
      req_f = 3'b010; exp_at(1, "e_own1", 0, 1, 1'b0, 1'b0); tick();
      req_f = 3'b001;
      bus(1'b1, HTRANS_NONSEQ, HBURST_WRAP8, 1'b0);
      exp_at(1, "e_ns", 0, 1, 1'b0, 1'b1); tick();
      bus(1'b1, HTRANS_SEQ, HBURST_WRAP8, 1'b0);
      exp_at(1, "e_s1", 0, 1, 1'b0, 1'b1); tick();
      exp_at(1, "e_s2", 0, 1, 1'b0, 1'b1); tick();
      bus(1'b1, HTRANS_IDLE, HBURST_WRAP8, 1'b0);
      exp_at(1, "e_cut", 0, 0, 1'b0, 1'b0); tick();
      bus(1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
      exp_at(1, "e_after", 0, 0, 1'b0, 1'b0); tick();

      // T6 reset in the middle of INCR16
      req_f = 3'b100; exp_at(1, "r_own2", 0, 2, 1'b0, 1'b0); tick();
      req_f = 3'b001;
      bus(1'b1, HTRANS_NONSEQ, HBURST_INCR16, 1'b0);
      exp_at(1, "r_ns", 0, 2, 1'b0, 1'b1); tick();
      bus(1'b1, HTRANS_SEQ, HBURST_INCR16, 1'b0);
      exp_at(1, "r_s1", 0, 2, 1'b0, 1'b1); tick();
      tick();
      do_reset("r_rst");
      req_f = 3'b000;
      exp_at(1, "r_nomem", 0, 0, 1'b0, 1'b0); tick();
      bus(1'b0, HTRANS_IDLE, HBURST_SINGLE, 1'b0);
      tick();

      done = 1'b1;
      repeat (2) @(negedge HCLK);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_mis);
      $finish;
   end

endmodule
